// File: rtl/ifu_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory and the execute core.
// master = fetch unit, slave = the memory/core environment around it.
interface ifu_fetch_if;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        fetch_fault;
  logic [31:0] fetch_cnt;

  modport master (
    input  next_pc, inst_ready, imem_req_ready, imem_resp_valid, imem_resp_data,
    output pc, instruction, inst_valid, imem_req_valid, imem_addr, fetch_fault, fetch_cnt
  );

  modport slave (
    output next_pc, inst_ready, imem_req_ready, imem_resp_valid, imem_resp_data,
    input  pc, instruction, inst_valid, imem_req_valid, imem_addr, fetch_fault, fetch_cnt
  );
endinterface

// File: rtl/ifu_fetch.sv
// RV32 instruction fetch unit: one outstanding word fetch, instruction handed to the core.
// Define IFU_ALIGN_CHECK_EN to trap misaligned PCs into a sticky FAULT state.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

`ifdef IFU_ALIGN_CHECK_EN
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, FAULT} state_t;
  localparam bit ALIGN_CHECK = 1'b1;
`else
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD} state_t;
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] addr_q;
  logic [31:0] cnt_q;
  logic        inst_valid_q;
  logic        req_valid_q;
`ifdef IFU_ALIGN_CHECK_EN
  logic        fault_q;
`endif

  // A misaligned PC never reaches the memory when the alignment trap is built in.
  function automatic logic issue_ok(input logic [1:0] lsb);
    return !ALIGN_CHECK || (lsb == 2'b00);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= BOOT;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      addr_q       <= {RESET_PC[31:2], 2'b00};
      cnt_q        <= '0;
      inst_valid_q <= 1'b0;
      req_valid_q  <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      fault_q      <= 1'b0;
`endif
    end else begin
      // NOTE: state and outputs use <= so every branch sees pre-edge values; = here would chain updates within one edge.
      unique case (state)
        BOOT: begin
          state       <= REQ;
          req_valid_q <= issue_ok(pc_q[1:0]);
          addr_q      <= {pc_q[31:2], 2'b00};
        end
        REQ: begin
`ifdef IFU_ALIGN_CHECK_EN
          if (pc_q[1:0] != 2'b00) begin
            state        <= FAULT;
            inst_valid_q <= 1'b1;
            inst_q       <= EBREAK;
            fault_q      <= 1'b1;
          end else
`endif
          if (bus.imem_req_ready) begin
            state       <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.imem_resp_valid) begin
            state        <= HOLD;
            inst_q       <= bus.imem_resp_data;
            inst_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.inst_ready) begin
            state        <= REQ;
            pc_q         <= bus.next_pc;
            cnt_q        <= cnt_q + 32'd1;
            inst_valid_q <= 1'b0;
            req_valid_q  <= issue_ok(bus.next_pc[1:0]);
            addr_q       <= {bus.next_pc[31:2], 2'b00};
          end
        end
`ifdef IFU_ALIGN_CHECK_EN
        FAULT: begin
          // Sticky until reset; the core may keep retiring the ebreak.
          if (bus.inst_ready) cnt_q <= cnt_q + 32'd1;
        end
`endif
        default: state <= BOOT;
      endcase
    end
  end

  assign bus.pc             = pc_q;
  assign bus.instruction    = inst_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_addr      = addr_q;
  assign bus.fetch_cnt      = cnt_q;
`ifdef IFU_ALIGN_CHECK_EN
  assign bus.fetch_fault    = fault_q;
`else
  assign bus.fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed timing cases, then randomized memory/core
// behaviour checked by a PC-stream scoreboard.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_if bus ();
  ifu_fetch #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Environment knobs, written by the main sequence, read by the bus driver.
  bit          scb_en      = 1'b1;
  bit          mem_rand    = 1'b0;
  bit          mem_rdy_val = 1'b1;
  bit          delay_rand  = 1'b0;
  int          resp_delay  = 0;
  bit          spur_rand   = 1'b0;
  int          spur_req    = 0;
  int          spur_done   = 0;
  bit          core_rand   = 1'b0;
  bit          core_rdy_val = 1'b0;
  logic [31:0] npc_val     = RESET_PC;

  // Scoreboard: PCs the core should see, in order, and the request addresses they imply.
  logic [31:0] fetch_q[$];
  logic [31:0] addr_q[$];
  int          exp_cnt  = 0;
  int          hs_total = 0;

  bit          outstanding = 1'b0;
  int          wait_left   = 0;
  logic [31:0] out_addr    = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0000_0413;
    return a ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},         bus.pc, RESET_PC);
    check({tag, "_instr"},      bus.instruction, 32'h0);
    check({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'h0);
    check({tag, "_req_valid"},  32'(bus.imem_req_valid), 32'h0);
    check({tag, "_addr"},       bus.imem_addr, RESET_PC);
    check({tag, "_fault"},      32'(bus.fetch_fault), 32'h0);
    check({tag, "_cnt"},        bus.fetch_cnt, 32'h0);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (!bus.inst_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(bus.inst_valid), 32'h1);
  endtask

  // Bus driver: instruction memory plus core. Observes at negedge, drives just after posedge.
  initial begin : bus_drv
    bus.next_pc         = RESET_PC;
    bus.inst_ready      = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        fetch_q.delete();
        addr_q.delete();
        fetch_q.push_back(RESET_PC);
        addr_q.push_back(RESET_PC);
      end else begin
        if (bus.inst_valid && bus.inst_ready) begin
          fetch_q.push_back(bus.next_pc);
          addr_q.push_back({bus.next_pc[31:2], 2'b00});
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          outstanding = 1'b1;
          out_addr    = bus.imem_addr;
          wait_left   = delay_rand ? int'($urandom_range(0, 3)) : resp_delay;
        end
      end
      @(posedge clk);
      #1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom;
      if (outstanding) begin
        if (wait_left == 0) begin
          bus.imem_resp_valid = 1'b1;
          bus.imem_resp_data  = mem_word(out_addr);
          outstanding         = 1'b0;
        end else begin
          wait_left--;
        end
      end else if (spur_req != spur_done || (spur_rand && $urandom_range(0, 5) == 0)) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hdead_beef;
        spur_done           = spur_req;
      end
      bus.imem_req_ready = mem_rand ? ($urandom_range(0, 3) != 0) : mem_rdy_val;
      bus.inst_ready     = core_rand ? ($urandom_range(0, 2) == 0) : core_rdy_val;
      bus.next_pc        = core_rand ? {16'h8000, 14'($urandom), 2'b00} : npc_val;
    end
  end

  // Monitor: pops the scoreboard on every request acceptance and every core handshake.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc   = '0;
  logic [31:0] prev_inst = '0;
  always @(negedge clk) begin
    if (!rst) begin
      exp_cnt   = 0;
      prev_hold = 1'b0;
    end else if (scb_en) begin
      if (bus.inst_valid || bus.imem_req_valid)
        check("valid_exclusive", 32'(bus.inst_valid && bus.imem_req_valid), 32'h0);
      if (prev_hold && bus.inst_valid) begin
        check("hold_pc_stable", bus.pc, prev_pc);
        check("hold_instr_stable", bus.instruction, prev_inst);
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("req_expected", 32'(addr_q.size() != 0), 32'h1);
        if (addr_q.size() != 0) check("req_addr", bus.imem_addr, addr_q.pop_front());
      end
      if (bus.inst_valid && bus.inst_ready) begin
        check("fetch_expected", 32'(fetch_q.size() != 0), 32'h1);
        if (fetch_q.size() != 0) begin
          logic [31:0] e;
          e = fetch_q.pop_front();
          check("fetch_pc", bus.pc, e);
          check("fetch_instr", bus.instruction, mem_word({e[31:2], 2'b00}));
        end
        check("fetch_cnt", bus.fetch_cnt, 32'(exp_cnt));
        check("fetch_fault_clear", 32'(bus.fetch_fault), 32'h0);
        exp_cnt++;
        hs_total++;
      end
      prev_hold = bus.inst_valid && !bus.inst_ready;
      prev_pc   = bus.pc;
      prev_inst = bus.instruction;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int hs_before;
    int base_cnt;

    repeat (3) @(negedge clk);
    check_reset_state("reset");

    // Zero-wait memory: request in cycle 1, instruction valid in cycle 3.
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("boot_no_req", 32'(bus.imem_req_valid), 32'h0);
    @(negedge clk);
    check("c1_req_valid", 32'(bus.imem_req_valid), 32'h1);
    check("c1_req_addr", bus.imem_addr, RESET_PC);
    @(negedge clk);
    check("c2_no_valid", 32'(bus.inst_valid), 32'h0);
    @(negedge clk);
    check("c3_inst_valid", 32'(bus.inst_valid), 32'h1);
    check("c3_pc", bus.pc, RESET_PC);
    check("c3_instr", bus.instruction, 32'h0000_0413);

    // Core stalls for 5 cycles.
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.inst_valid), 32'h1);
      check("stall_instr", bus.instruction, 32'h0000_0413);
      check("stall_no_req", 32'(bus.imem_req_valid), 32'h0);
      check("stall_cnt", bus.fetch_cnt, 32'h0);
    end

    // Handshake with a redirect; next request one cycle later.
    npc_val      = 32'h8000_0100;
    core_rdy_val = 1'b1;
    @(negedge clk);
    check("hs1_seen", 32'(bus.inst_valid && bus.inst_ready), 32'h1);
    core_rdy_val = 1'b0;
    resp_delay   = 4;
    @(negedge clk);
    check("hs1_next_req", 32'(bus.imem_req_valid), 32'h1);
    check("hs1_next_addr", bus.imem_addr, 32'h8000_0100);
    check("hs1_cnt", bus.fetch_cnt, 32'h1);
    mem_rdy_val = 1'b0;

    // Reset pulse while the fetch is outstanding; its late response must be dropped.
    @(negedge clk);
    check("inflight_no_req", 32'(bus.imem_req_valid), 32'h0);
    check("inflight_no_valid", 32'(bus.inst_valid), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("mid_reset");
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stale_resp_ignored", 32'(bus.inst_valid), 32'h0);
    end
    check("post_reset_req", 32'(bus.imem_req_valid), 32'h1);
    check("post_reset_addr", bus.imem_addr, RESET_PC);
    resp_delay  = 0;
    mem_rdy_val = 1'b1;
    wait_valid("post_reset_valid", 20);
    check("post_reset_pc", bus.pc, RESET_PC);
    check("post_reset_instr", bus.instruction, 32'h0000_0413);
    check("post_reset_cnt", bus.fetch_cnt, 32'h0);

    // Memory stalls the request 3 cycles, a spurious response lands in REQ, data 4 cycles late.
    npc_val      = 32'h8000_0200;
    core_rdy_val = 1'b1;
    mem_rdy_val  = 1'b0;
    resp_delay   = 4;
    @(negedge clk);
    check("hs2_seen", 32'(bus.inst_valid && bus.inst_ready), 32'h1);
    core_rdy_val = 1'b0;
    spur_req++;
    repeat (3) begin
      @(negedge clk);
      check("stalled_req_valid", 32'(bus.imem_req_valid), 32'h1);
      check("stalled_req_addr", bus.imem_addr, 32'h8000_0200);
      check("spurious_no_valid", 32'(bus.inst_valid), 32'h0);
    end
    mem_rdy_val = 1'b1;
    wait_valid("delayed_valid", 30);
    check("delayed_pc", bus.pc, 32'h8000_0200);
    check("delayed_instr", bus.instruction, mem_word(32'h8000_0200));

    // Randomized memory and core behaviour under the scoreboard.
    hs_before  = hs_total;
    mem_rand   = 1'b1;
    delay_rand = 1'b1;
    spur_rand  = 1'b1;
    core_rand  = 1'b1;
    repeat (3000) @(negedge clk);
    check("random_progress", 32'(hs_total - hs_before > 150), 32'h1);

    core_rand    = 1'b0;
    core_rdy_val = 1'b0;
    mem_rand     = 1'b0;
    mem_rdy_val  = 1'b1;
    delay_rand   = 1'b0;
    resp_delay   = 0;
    spur_rand    = 1'b0;
    repeat (2) @(negedge clk);
    wait_valid("pre_misalign_valid", 40);

    // Misaligned redirect.
    scb_en       = 1'b0;
    base_cnt     = exp_cnt;
    npc_val      = 32'h8000_0102;
    core_rdy_val = 1'b1;
    @(negedge clk);
    check("hs3_seen", 32'(bus.inst_valid && bus.inst_ready), 32'h1);
    core_rdy_val = 1'b0;
    @(negedge clk);
`ifdef IFU_ALIGN_CHECK_EN
    check("misalign_no_req", 32'(bus.imem_req_valid), 32'h0);
    @(negedge clk);
    check("fault_flag", 32'(bus.fetch_fault), 32'h1);
    check("fault_valid", 32'(bus.inst_valid), 32'h1);
    check("fault_instr", bus.instruction, EBREAK);
    check("fault_pc", bus.pc, 32'h8000_0102);
    check("fault_cnt", bus.fetch_cnt, 32'(base_cnt + 1));
    core_rdy_val = 1'b1;
    repeat (2) @(negedge clk);
    core_rdy_val = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("fault_sticky", 32'(bus.fetch_fault), 32'h1);
      check("fault_held_valid", 32'(bus.inst_valid), 32'h1);
      check("fault_held_instr", bus.instruction, EBREAK);
      check("fault_held_pc", bus.pc, 32'h8000_0102);
      check("fault_no_req", 32'(bus.imem_req_valid), 32'h0);
      check("fault_hs_cnt", bus.fetch_cnt, 32'(base_cnt + 3));
    end
`else
    check("masked_req_valid", 32'(bus.imem_req_valid), 32'h1);
    check("masked_req_addr", bus.imem_addr, 32'h8000_0100);
    check("masked_no_fault", 32'(bus.fetch_fault), 32'h0);
    check("masked_cnt", bus.fetch_cnt, 32'(base_cnt + 1));
    wait_valid("masked_valid", 20);
    check("masked_pc", bus.pc, 32'h8000_0102);
    check("masked_instr", bus.instruction, mem_word(32'h8000_0100));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
